// File: rtl/csi_rx_pkg.sv
// Shared definitions for the CSI-2 receive clock-lane supervisor.
//   clk_state_e   : supervisor FSM states
//   DEF_*         : default window length and edge-count limits, derived from
//                   nominal reference/byte clock frequencies and the toggle
//                   divider applied in the byte clock domain.
package csi_rx_pkg;

  typedef enum logic [1:0] {
    HOLD_CLR = 2'd0,
    MEASURE  = 2'd1,
    RELEASE  = 2'd2,
    LOCKED   = 2'd3
  } clk_state_e;

  localparam int REF_FREQ_MHZ         = 100;
  localparam int BYTE_FREQ_MHZ        = 100;
  // byte_toggle changes once every 8 byte clocks
  localparam int BYTE_CLKS_PER_TOGGLE = 8;
  localparam int DEF_WINDOW_CYCLES    = 1024;
  // Edges expected per window at nominal rates (128 for the defaults)
  localparam int NOM_EDGES     = (DEF_WINDOW_CYCLES * BYTE_FREQ_MHZ) /
                                 (REF_FREQ_MHZ * BYTE_CLKS_PER_TOGGLE);
  // Accept -25 % .. +25 % around nominal
  localparam int DEF_MIN_EDGES = (NOM_EDGES * 3) / 4;
  localparam int DEF_MAX_EDGES = (NOM_EDGES * 5) / 4;

endpackage

// File: rtl/csi_rx_toggle_sync.sv
// Synchroniser and edge detector for the byte-domain toggle.
//   ref_clock    : reference clock
//   reset        : asynchronous active-high reset
//   toggle_async : toggle signal from the byte clock domain
//   edge_pulse   : one-cycle pulse per toggle transition, visible
//                  SYNC_STAGES cycles after the input transition and counted
//                  by the consumer on the following edge
module csi_rx_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic ref_clock,
  input  logic reset,
  input  logic toggle_async,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge ref_clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_async};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/csi_rx_clk_lane_ctrl.sv
// CSI-2 receive clock-lane supervisor. Measures the recovered byte clock rate
// via a toggle counted over fixed reference-clock windows, holds the regional
// clock buffers in CLR until the lane is measured good, then releases the
// per-lane deserialiser resets in a staggered sequence and watches for loss.
//
// Ports:
//   ref_clock    : free-running reference clock
//   reset        : asynchronous active-high reset
//   byte_toggle  : async toggle, one transition per 8 byte clocks
//   bufr_clr     : CLR for bit/byte BUFRs
//   serdes_reset : per-lane ISERDES/aligner reset, active-high
//   clk_locked   : lane measured in range and all lanes released
//   clk_lost     : one-cycle pulse when loss is declared
//   edge_count   : edge count of the last completed window
//
// Build option CSI_RX_CLK_RELOCK_EN: when defined, loss of the clock lane
// re-enters HOLD_CLR and re-initialises. When undefined, LOCKED is sticky
// until reset; loss only pulses clk_lost.
//
// state    | meaning
// HOLD_CLR | BUFR CLR asserted, all lanes in reset, window counter frozen
// MEASURE  | CLR released; first window discarded, second window judged
// RELEASE  | lane resets released every LANE_STAGGER cycles, window watched
// LOCKED   | clk_locked high; consecutive bad windows counted toward loss
module csi_rx_clk_lane_ctrl
  import csi_rx_pkg::*;
#(
  parameter int NUM_LANES     = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int MIN_EDGES     = DEF_MIN_EDGES,
  parameter int MAX_EDGES     = DEF_MAX_EDGES,
  parameter int CLR_CYCLES    = 16,
  parameter int LANE_STAGGER  = 8,
  parameter int LOSS_WINDOWS  = 2
) (
  input  logic                                 ref_clock,
  input  logic                                 reset,
  input  logic                                 byte_toggle,
  output logic                                 bufr_clr,
  output logic [NUM_LANES-1:0]                 serdes_reset,
  output logic                                 clk_locked,
  output logic                                 clk_lost,
  output logic [$clog2(WINDOW_CYCLES+1)-1:0]   edge_count
);

  localparam int CNT_W = $clog2(WINDOW_CYCLES + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int STG_W = $clog2(NUM_LANES * LANE_STAGGER + 1);
  localparam int BAD_W = $clog2(LOSS_WINDOWS + 1);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_EDGES);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_DONE = STG_W'(NUM_LANES * LANE_STAGGER);
  localparam logic [BAD_W-1:0] BAD_LOSS = BAD_W'(LOSS_WINDOWS);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(LOSS_WINDOWS - 1);

  clk_state_e           state_q, state_d;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0]     win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     edge_count_q, edge_count_d;
  logic                 first_done_q, first_done_d;
  logic [STG_W-1:0]     stg_cnt_q, stg_cnt_d;
  logic [BAD_W-1:0]     bad_cnt_q, bad_cnt_d;
  logic                 bufr_clr_q, bufr_clr_d;
  logic [NUM_LANES-1:0] serdes_reset_q, serdes_reset_d;
  logic                 clk_locked_q, clk_locked_d;
  logic                 clk_lost_q, clk_lost_d;

  logic edge_pulse;
  logic win_wrap;
  logic window_ok;

  csi_rx_toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_toggle_sync (
    .ref_clock    (ref_clock),
    .reset        (reset),
    .toggle_async (byte_toggle),
    .edge_pulse   (edge_pulse)
  );

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = '0;
    win_cnt_d      = '0;
    acc_d          = '0;
    edge_count_d   = edge_count_q;
    first_done_d   = first_done_q;
    stg_cnt_d      = '0;
    bad_cnt_d      = '0;
    serdes_reset_d = serdes_reset_q;
    clk_lost_d     = 1'b0;
    win_wrap       = 1'b0;
    window_ok      = 1'b0;

    // Window counter and accumulator are frozen at zero in HOLD_CLR, so
    // edges seen there are dropped and MEASURE starts from a clean window.
    if (state_q != HOLD_CLR) begin
      win_wrap  = (win_cnt_q == WIN_LAST);
      window_ok = (acc_q >= MIN_CNT) && (acc_q <= MAX_CNT);
      if (win_wrap) begin
        edge_count_d = acc_q;
        // An edge on the wrap cycle belongs to the next window
        acc_d        = CNT_W'(edge_pulse);
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        acc_d     = (edge_pulse && (acc_q != ACC_MAX)) ? acc_q + 1'b1 : acc_q;
      end
    end

    case (state_q)
      HOLD_CLR: begin
        clr_cnt_d      = clr_cnt_q + 1'b1;
        serdes_reset_d = '1;
        first_done_d   = 1'b0;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (win_wrap) begin
          if (!first_done_q) begin
            first_done_d = 1'b1;
          end else if (window_ok) begin
            state_d = RELEASE;
          end else begin
            state_d = HOLD_CLR;
          end
        end
      end

      RELEASE: begin
        stg_cnt_d = stg_cnt_q + 1'b1;
        if (win_wrap && !window_ok) begin
          state_d        = HOLD_CLR;
          serdes_reset_d = '1;
        end else begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (stg_cnt_d == STG_W'((i + 1) * LANE_STAGGER)) begin
              serdes_reset_d[i] = 1'b0;
            end
          end
          if (stg_cnt_d == STG_DONE) begin
            state_d = LOCKED;
          end
        end
      end

      LOCKED: begin
        bad_cnt_d = bad_cnt_q;
        if (win_wrap) begin
          if (window_ok) begin
            bad_cnt_d = '0;
          end else if (bad_cnt_q == BAD_LAST) begin
            bad_cnt_d  = BAD_LOSS;
            clk_lost_d = 1'b1;
`ifdef CSI_RX_CLK_RELOCK_EN
            state_d        = HOLD_CLR;
            serdes_reset_d = '1;
`else
            // Sticky lock: counter parks at the limit until a good window
            state_d = LOCKED;
`endif
          end else if (bad_cnt_q < BAD_LOSS) begin
            bad_cnt_d = bad_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d        = HOLD_CLR;
        serdes_reset_d = '1;
      end
    endcase

    bufr_clr_d   = (state_d == HOLD_CLR);
    // Asserted one cycle after entering LOCKED, dropped with the loss edge
    clk_locked_d = (state_q == LOCKED) && (state_d == LOCKED);
  end

  always_ff @(posedge ref_clock or posedge reset) begin
    if (reset) begin
      state_q        <= HOLD_CLR;
      clr_cnt_q      <= '0;
      win_cnt_q      <= '0;
      acc_q          <= '0;
      edge_count_q   <= '0;
      first_done_q   <= 1'b0;
      stg_cnt_q      <= '0;
      bad_cnt_q      <= '0;
      bufr_clr_q     <= 1'b1;
      serdes_reset_q <= '1;
      clk_locked_q   <= 1'b0;
      clk_lost_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      win_cnt_q      <= win_cnt_d;
      acc_q          <= acc_d;
      edge_count_q   <= edge_count_d;
      first_done_q   <= first_done_d;
      stg_cnt_q      <= stg_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
      bufr_clr_q     <= bufr_clr_d;
      serdes_reset_q <= serdes_reset_d;
      clk_locked_q   <= clk_locked_d;
      clk_lost_q     <= clk_lost_d;
    end
  end

  assign bufr_clr     = bufr_clr_q;
  assign serdes_reset = serdes_reset_q;
  assign clk_locked   = clk_locked_q;
  assign clk_lost     = clk_lost_q;
  assign edge_count   = edge_count_q;

endmodule

// File: tb/tb_csi_rx_clk_lane_ctrl.sv
// Bench for csi_rx_clk_lane_ctrl. Cycle k is the interval after the k-th
// ref_clock rising edge following reset release. Toggles are scheduled per
// measurement window so each window sees a chosen number of edges; expected
// results follow from window arithmetic (MEASURE entry at CLR_CYCLES, a
// window judged every WINDOW_CYCLES, lanes released every LANE_STAGGER).
module tb_csi_rx_clk_lane_ctrl;

  localparam int NL   = 2;
  localparam int WIN  = 1024;
  localparam int MINE = 96;
  localparam int MAXE = 160;
  localparam int CLRC = 16;
  localparam int STAG = 8;
  localparam int M0   = CLRC;
  localparam int SCHED_LEN = 16384;

  logic          ref_clock = 1'b0;
  logic          reset = 1'b1;
  logic          byte_toggle = 1'b0;
  logic          bufr_clr;
  logic [NL-1:0] serdes_reset;
  logic          clk_locked;
  logic          clk_lost;
  logic [10:0]   edge_count;

  csi_rx_clk_lane_ctrl #(
    .NUM_LANES     (NL),
    .SYNC_STAGES   (2),
    .WINDOW_CYCLES (WIN),
    .MIN_EDGES     (MINE),
    .MAX_EDGES     (MAXE),
    .CLR_CYCLES    (CLRC),
    .LANE_STAGGER  (STAG),
    .LOSS_WINDOWS  (2)
  ) dut (
    .ref_clock    (ref_clock),
    .reset        (reset),
    .byte_toggle  (byte_toggle),
    .bufr_clr     (bufr_clr),
    .serdes_reset (serdes_reset),
    .clk_locked   (clk_locked),
    .clk_lost     (clk_lost),
    .edge_count   (edge_count)
  );

  always #5 ref_clock = ~ref_clock;

  int cyc;
  bit sched [SCHED_LEN];
  int checks;
  int failures;
  int lost_cnt;
  int lost_last;

  typedef struct {
    int n;
    bit exp_lock;
  } vec_t;
  vec_t vecs[$];

  // Toggle driver: one transition in every scheduled cycle
  initial forever begin
    @(posedge ref_clock);
    #1;
    if (reset) cyc = 0;
    else cyc = cyc + 1;
    if (!reset && cyc < SCHED_LEN && sched[cyc]) byte_toggle = ~byte_toggle;
  end

  // clk_lost pulse monitor
  initial forever begin
    @(negedge ref_clock);
    if (reset) lost_cnt = 0;
    else if (clk_lost) begin
      lost_cnt  = lost_cnt + 1;
      lost_last = cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic bit model_lock(input int n);
    return (n >= MINE) && (n <= MAXE);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    @(negedge ref_clock);
    while (cyc < c) @(negedge ref_clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < SCHED_LEN; i++) sched[i] = 1'b0;
    repeat (3) @(posedge ref_clock);
    #2;
    reset = 1'b0;
  endtask

  // Place n toggles inside window w of a measurement run that entered
  // MEASURE at cycle m; pulses land well clear of both window boundaries.
  task automatic sched_window(input int m, input int w, input int n);
    int base;
    int pos;
    base = m + w * WIN;
    for (int i = 0; i < n; i++) begin
      pos = base + 2 + (i * 1000) / n + int'($urandom_range(0, 1));
      sched[pos] = 1'b1;
    end
  endtask

  task automatic run_vec(input string tag, input int n, input bit exp_lock);
    int e;
    do_reset();
    // Edges during HOLD_CLR must not reach the first window
    sched[2] = 1'b1; sched[5] = 1'b1; sched[8] = 1'b1;
    sched_window(M0, 0, n);
    sched_window(M0, 1, n);
    e = M0 + 2 * WIN;
    wait_to(CLRC - 1);
    chk({tag, "_clr_hold"}, bufr_clr, 1);
    wait_to(CLRC);
    chk({tag, "_clr_fall"}, bufr_clr, 0);
    wait_to(M0 + WIN);
    chk({tag, "_cnt_w0"}, edge_count, n);
    wait_to(e);
    chk({tag, "_cnt_w1"}, edge_count, n);
    if (exp_lock) begin
      chk({tag, "_clr_rel"}, bufr_clr, 0);
      wait_to(e + STAG - 1);
      chk({tag, "_srst_pre"}, serdes_reset, 2'b11);
      wait_to(e + STAG);
      chk({tag, "_srst_l0"}, serdes_reset, 2'b10);
      wait_to(e + 2 * STAG);
      chk({tag, "_srst_l1"}, serdes_reset, 2'b00);
      chk({tag, "_lock_early"}, clk_locked, 0);
      wait_to(e + 2 * STAG + 1);
      chk({tag, "_lock"}, clk_locked, 1);
    end else begin
      chk({tag, "_clr_back"}, bufr_clr, 1);
      chk({tag, "_srst_held"}, serdes_reset, 2'b11);
      wait_to(e + 2 * STAG + 1);
      chk({tag, "_nolock"}, clk_locked, 0);
    end
  endtask

  initial begin
    int e;
    int m2;
    checks   = 0;
    failures = 0;

    #12;
    chk("rst_bufr_clr", bufr_clr, 1);
    chk("rst_serdes", serdes_reset, 2'b11);
    chk("rst_locked", clk_locked, 0);
    chk("rst_lost", clk_lost, 0);
    chk("rst_edge_count", edge_count, 0);

    vecs.push_back('{128, 1'b1});
    vecs.push_back('{MINE, 1'b1});
    vecs.push_back('{MAXE, 1'b1});
    vecs.push_back('{MINE - 1, 1'b0});
    vecs.push_back('{MAXE + 1, 1'b0});
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(80, 176));
      vecs.push_back('{n, model_lock(n)});
    end
    foreach (vecs[i]) run_vec($sformatf("vec%0d_n%0d", i, vecs[i].n), vecs[i].n, vecs[i].exp_lock);

    // Async reset while lane 0 is released and lane 1 is not
    do_reset();
    sched_window(M0, 0, 128);
    sched_window(M0, 1, 128);
    e = M0 + 2 * WIN;
    wait_to(e + STAG + 2);
    chk("arst_pre_serdes", serdes_reset, 2'b10);
    @(posedge ref_clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_bufr_clr", bufr_clr, 1);
    chk("arst_serdes", serdes_reset, 2'b11);
    chk("arst_locked", clk_locked, 0);
    chk("arst_lost", clk_lost, 0);
    chk("arst_edge_count", edge_count, 0);

    // Single glitch windows never accumulate to a loss
    do_reset();
    sched_window(M0, 0, 128);
    sched_window(M0, 1, 128);
    sched_window(M0, 2, 50);
    sched_window(M0, 3, 128);
    sched_window(M0, 4, 50);
    sched_window(M0, 5, 128);
    wait_to(M0 + 3 * WIN);
    chk("glitch_cnt50", edge_count, 50);
    chk("glitch_locked_a", clk_locked, 1);
    wait_to(M0 + 4 * WIN);
    chk("glitch_cnt128", edge_count, 128);
    wait_to(M0 + 6 * WIN + 1);
    chk("glitch_no_lost", lost_cnt, 0);
    chk("glitch_locked_b", clk_locked, 1);

    // Loss: toggling stops after window 2
    do_reset();
    sched_window(M0, 0, 128);
    sched_window(M0, 1, 128);
    sched_window(M0, 2, 128);
    m2 = M0 + 5 * WIN + CLRC;
`ifdef CSI_RX_CLK_RELOCK_EN
    sched[m2 - 14] = 1'b1; sched[m2 - 10] = 1'b1; sched[m2 - 6] = 1'b1;
    sched_window(m2, 0, 128);
    sched_window(m2, 1, 128);
`else
    sched_window(M0, 6, 128);
`endif
    wait_to(M0 + 2 * WIN + 2 * STAG + 1);
    chk("loss_locked_first", clk_locked, 1);
    wait_to(M0 + 4 * WIN);
    chk("loss_cnt_zero", edge_count, 0);
    chk("loss_one_bad_locked", clk_locked, 1);
    chk("loss_one_bad_nolost", lost_cnt, 0);
    wait_to(M0 + 5 * WIN - 1);
    chk("loss_pulse_pre", clk_lost, 0);
    wait_to(M0 + 5 * WIN);
    chk("loss_pulse", clk_lost, 1);
`ifdef CSI_RX_CLK_RELOCK_EN
    chk("loss_locked_drop", clk_locked, 0);
    chk("loss_bufr_clr", bufr_clr, 1);
    chk("loss_serdes", serdes_reset, 2'b11);
    wait_to(M0 + 5 * WIN + 1);
    chk("loss_pulse_width", clk_lost, 0);
    chk("loss_pulse_count", lost_cnt, 1);
    wait_to(m2 + WIN);
    chk("relock_cnt_w0", edge_count, 128);
    wait_to(m2 + 2 * WIN + 2 * STAG);
    chk("relock_not_yet", clk_locked, 0);
    wait_to(m2 + 2 * WIN + 2 * STAG + 1);
    chk("relock_locked", clk_locked, 1);
    chk("relock_serdes", serdes_reset, 2'b00);
`else
    chk("sticky_locked", clk_locked, 1);
    chk("sticky_bufr_clr", bufr_clr, 0);
    chk("sticky_serdes", serdes_reset, 2'b00);
    wait_to(M0 + 5 * WIN + 1);
    chk("sticky_pulse_width", clk_lost, 0);
    wait_to(M0 + 6 * WIN + 1);
    chk("sticky_no_repeat", lost_cnt, 1);
    wait_to(M0 + 7 * WIN);
    chk("sticky_good_cnt", edge_count, 128);
    wait_to(M0 + 9 * WIN - 1);
    chk("sticky_second_pre", lost_cnt, 1);
    wait_to(M0 + 9 * WIN);
    chk("sticky_second_pulse", clk_lost, 1);
    wait_to(M0 + 9 * WIN + 1);
    chk("sticky_pulse_count", lost_cnt, 2);
    chk("sticky_locked_end", clk_locked, 1);
    chk("sticky_serdes_end", serdes_reset, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
